// File: rtl/xsleenacore_pkg.sv
// Shared definitions for the xsleenacore palette loader.
// The RD_ACC state exists only when XSLEENACORE_PLOADER_VERIFY_EN is defined.
package xsleenacore_pkg;

    localparam int PLRAM_BYTES    = 1024;
    localparam int PLRAM_BANK_BIT = 9;     // AB[9]=1 selects the MSB (B) RAM

    localparam logic [7:0] PL_DB_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_BYTE  = 3'd1,
        WAIT_BLANK = 3'd2,
        WR_ACC     = 3'd3,
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
        RD_ACC     = 3'd4,
`endif
        CHECK      = 3'd5,
        DONE       = 3'd6
    } ploader_state_t;

endpackage

// File: rtl/xsleenacore_access_timer.sv
// Palette-bus access timer: down-counter loaded with ACCESS_CYCLES-1 on the
// cycle before an access starts; 'last' flags the final access clock.
// With XSLEENACORE_PLOADER_VERIFY_EN, 'sample' marks where read data is taken.
module xsleenacore_access_timer #(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
    ,
    output logic sample
`endif
);

    localparam logic [3:0] LOAD_VAL = 4'(ACCESS_CYCLES - 1);

    logic [3:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 4'd0);

`ifdef XSLEENACORE_PLOADER_VERIFY_EN
    // The mixer drives read data for the whole access; take it on the last clock.
    assign sample = last;
`endif

endmodule

// File: rtl/xsleenacore_palette_loader.sv
// Palette loader: streams NUM_BYTES bytes into the video mixer palette RAM,
// byte k at AB=k, optionally only during blanking.
// Define XSLEENACORE_PLOADER_VERIFY_EN to add a read-back verify after each write.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_BYTE  | s_ready high, waiting for a source byte
// WAIT_BLANK | byte held, waiting for BLKn low
// WR_ACC     | palette write access, ACCESS_CYCLES clocks
// RD_ACC     | palette read-back access (verify build only)
// CHECK      | last-address test / address increment
// DONE       | one-clock done pulse
module xsleenacore_palette_loader
    import xsleenacore_pkg::*;
#(
    parameter int ACCESS_CYCLES = 4,
    parameter int NUM_BYTES     = 1024,
    parameter bit BLANK_ONLY    = 1'b1
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       start,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       BLKn,
    input  logic [7:0] DB_in,
    output logic       PLSELn,
    output logic [9:0] AB,
    output logic [7:0] DB_out,
    output logic       RW,
    output logic       WDn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [9:0] err_addr
);

    localparam logic [9:0] LAST_ADDR = 10'(NUM_BYTES - 1);

    ploader_state_t state_q, state_d;
    logic [9:0]     addr_q, addr_d;
    logic [7:0]     byte_q, byte_d;
    logic           tmr_load;
    logic           tmr_last;

`ifdef XSLEENACORE_PLOADER_VERIFY_EN
    logic       tmr_sample;
    logic       err_q, err_d;
    logic [9:0] err_addr_q, err_addr_d;
`else
    logic       unused_db_in;
    assign unused_db_in = ^DB_in;
`endif

    xsleenacore_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (RSTn),
        .load  (tmr_load),
        .last  (tmr_last)
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
        ,
        .sample(tmr_sample)
`endif
    );

    // Next-state logic and bus outputs; outputs decode from registered state so
    // reset forces the idle bus values without waiting for a clock.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        byte_d   = byte_q;
        tmr_load = 1'b0;
        PLSELn   = 1'b1;
        RW       = 1'b1;
        WDn      = 1'b1;
        AB       = 10'd0;
        DB_out   = PL_DB_IDLE;
        s_ready  = 1'b0;
        done     = 1'b0;
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
        err_d      = err_q;
        err_addr_d = err_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_BYTE;
                    addr_d  = 10'd0;
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
                    err_d      = 1'b0;
                    err_addr_d = 10'd0;
`endif
                end
            end
            WAIT_BYTE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    byte_d = s_data;
                    if (BLANK_ONLY) begin
                        state_d = WAIT_BLANK;
                    end else begin
                        state_d  = WR_ACC;
                        tmr_load = 1'b1;
                    end
                end
            end
            WAIT_BLANK: begin
                if (!BLKn) begin
                    state_d  = WR_ACC;
                    tmr_load = 1'b1;
                end
            end
            WR_ACC: begin
                PLSELn = 1'b0;
                RW     = 1'b0;
                WDn    = 1'b0;
                AB     = addr_q;
                DB_out = byte_q;
                if (tmr_last) begin
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
                    state_d  = RD_ACC;
                    tmr_load = 1'b1;
`else
                    state_d  = CHECK;
`endif
                end
            end
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
            RD_ACC: begin
                PLSELn = 1'b0;
                AB     = addr_q;
                if (tmr_sample && (DB_in != byte_q) && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                end
                if (tmr_last) begin
                    state_d = CHECK;
                end
            end
`endif
            CHECK: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 10'd1;
                    state_d = WAIT_BYTE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address, latched byte and verify status registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            addr_q  <= 10'd0;
            byte_q  <= 8'd0;
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
            err_q      <= 1'b0;
            err_addr_q <= 10'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);

`ifdef XSLEENACORE_PLOADER_VERIFY_EN
    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign err      = 1'b0;
    assign err_addr = 10'd0;
`endif

endmodule

// File: tb/tb_xsleenacore_palette_loader.sv
// Bench for xsleenacore_palette_loader: instance A (4 bytes, no blanking gate)
// and instance B (default 1024 bytes, blank-only), each with a mixer RAM model.
module tb_xsleenacore_palette_loader;

    logic clk = 1'b0;
    logic RSTn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A ----------------
    logic       start_a = 0, s_valid_a = 0, s_ready_a, blkn_a = 1;
    logic [7:0] s_data_a = 0, db_in_a, db_out_a;
    logic       plseln_a, rw_a, wdn_a, busy_a, done_a, err_a;
    logic [9:0] ab_a, err_addr_a;
    logic [7:0] ram_a [0:1023];
    int         done_cnt_a = 0;

    xsleenacore_palette_loader #(.ACCESS_CYCLES(4), .NUM_BYTES(4), .BLANK_ONLY(1'b0)) dut_a (
        .clk(clk), .RSTn(RSTn), .start(start_a), .s_valid(s_valid_a), .s_data(s_data_a),
        .s_ready(s_ready_a), .BLKn(blkn_a), .DB_in(db_in_a), .PLSELn(plseln_a), .AB(ab_a),
        .DB_out(db_out_a), .RW(rw_a), .WDn(wdn_a), .busy(busy_a), .done(done_a),
        .err(err_a), .err_addr(err_addr_a));

    assign db_in_a = ram_a[ab_a];

    // Mixer model A: write RAM during write accesses, count done pulses.
    always @(negedge clk) begin
        if (!plseln_a && !wdn_a && !rw_a) ram_a[ab_a] <= db_out_a;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    // ---------------- instance B ----------------
    logic       start_b = 0, s_valid_b = 0, s_ready_b, blkn_b = 1;
    logic [7:0] s_data_b = 0, db_in_b, db_out_b;
    logic       plseln_b, rw_b, wdn_b, busy_b, done_b, err_b;
    logic [9:0] ab_b, err_addr_b;
    logic [7:0] ram_b [0:1023];
    logic       fault_b = 0;
    logic       wdn_prev_b = 1;
    int         done_cnt_b = 0, wr_cnt_b = 0, wr_hi_cnt_b = 0;

    xsleenacore_palette_loader dut_b (
        .clk(clk), .RSTn(RSTn), .start(start_b), .s_valid(s_valid_b), .s_data(s_data_b),
        .s_ready(s_ready_b), .BLKn(blkn_b), .DB_in(db_in_b), .PLSELn(plseln_b), .AB(ab_b),
        .DB_out(db_out_b), .RW(rw_b), .WDn(wdn_b), .busy(busy_b), .done(done_b),
        .err(err_b), .err_addr(err_addr_b));

    assign db_in_b = (fault_b && ab_b == 10'd5) ? 8'h00 : ram_b[ab_b];

    // Mixer model B: RAM write, write-access starts, MSB-bank writes, done pulses.
    always @(negedge clk) begin
        if (!plseln_b && !wdn_b && !rw_b) ram_b[ab_b] <= db_out_b;
        if (!wdn_b && wdn_prev_b) begin
            wr_cnt_b <= wr_cnt_b + 1;
            if (ab_b[9]) wr_hi_cnt_b <= wr_hi_cnt_b + 1;
        end
        wdn_prev_b <= wdn_b;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 7 + 3) ^ (k >> 8));
    endfunction

    task automatic feed_b(input logic [7:0] d, output bit ok);
        int n = 0;
        while (!s_ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = s_ready_b;
        if (ok) begin
            s_valid_b = 1'b1;
            s_data_b  = d;
            @(negedge clk);
            s_valid_b = 1'b0;
        end
    endtask

    task automatic wait_write_b(output bit ok);
        int n = 0;
        while (wdn_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = !wdn_b;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] addr;
        int         acc_len;
        bit         start_while_busy;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n, bad, snap_done, snap_wr, snap_hi, feed_fail;
        bit   ok;

        vecs[0] = '{8'h11, 10'd0, 4, 1'b0};
        vecs[1] = '{8'h22, 10'd1, 4, 1'b0};
        vecs[2] = '{8'h33, 10'd2, 4, 1'b1};
        vecs[3] = '{8'h44, 10'd3, 4, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_plseln", plseln_a, 1);
        chk("rst_bus", {wdn_a, rw_a, db_out_a, ab_a}, {1'b1, 1'b1, 8'hFF, 10'd0});
        chk("rst_status", {busy_a, s_ready_a, done_a, err_a, err_addr_a}, 0);
        chk("rst_b_bus", {plseln_b, wdn_b, rw_b, db_out_b, busy_b}, {1'b1, 1'b1, 1'b1, 8'hFF, 1'b0});
        RSTn = 1'b1;
        @(negedge clk);

        // Start pulse: busy and s_ready on the next clock
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("start_busy_ready", {busy_a, s_ready_a}, 2'b11);

        // Four-byte load, table driven
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].start_while_busy) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
            n = 0;
            while (!s_ready_a && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("a_ready_seen", s_ready_a, 1);
            s_valid_a = 1'b1;
            s_data_a  = vecs[i].data;
            @(negedge clk);
            s_valid_a = 1'b0;
            n = 0;
            bad = 0;
            while (!wdn_a && n < 20) begin
                if (plseln_a || rw_a || ab_a != vecs[i].addr || db_out_a != vecs[i].data || s_ready_a)
                    bad++;
                n++;
                @(negedge clk);
            end
            chk("a_write_len", n, vecs[i].acc_len);
            chk("a_write_bus", bad, 0);
        end
        n = 0;
        while (busy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_complete", busy_a, 0);
        chk("a_done_once", done_cnt_a, 1);
        chk("a_ram", {ram_a[0], ram_a[1], ram_a[2], ram_a[3]}, 32'h11223344);
        chk("a_err_clear", {err_a, err_addr_a}, 0);

        // Blank-gated first byte of a full load, with DB_in fault at AB=5
        fault_b = 1'b1;
        snap_done = done_cnt_b;
        snap_wr   = wr_cnt_b;
        snap_hi   = wr_hi_cnt_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        feed_b(pat(0), ok);
        chk("b_feed0", ok, 1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (!plseln_b || s_ready_b) bad++;
            @(negedge clk);
        end
        chk("b_blank_hold", bad, 0);
        blkn_b = 1'b0;
        @(negedge clk);
        chk("b_write_after_blank", {plseln_b, wdn_b, ab_b, db_out_b}, {1'b0, 1'b0, 10'd0, pat(0)});
        // Blank ends mid-access: access still runs its full length
        blkn_b = 1'b1;
        n = 1;
        @(negedge clk);
        while (!wdn_b && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("b_blank_end_len", n, 4);
        blkn_b = 1'b0;

        feed_fail = 0;
        for (int k = 1; k < 1024; k++) begin
            feed_b(pat(k), ok);
            if (!ok) feed_fail++;
        end
        chk("b_feed_timeouts", feed_fail, 0);
        n = 0;
        while (busy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_complete", busy_b, 0);
        chk("b_done_once", done_cnt_b - snap_done, 1);
        chk("b_write_count", wr_cnt_b - snap_wr, 1024);
        chk("b_msb_bank_writes", wr_hi_cnt_b - snap_hi, 512);
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (ram_b[k] !== pat(k)) bad++;
        chk("b_ram_contents", bad, 0);
`ifdef XSLEENACORE_PLOADER_VERIFY_EN
        chk("b_err", {err_b, err_addr_b}, {1'b1, 10'd5});
`else
        chk("b_err", {err_b, err_addr_b}, 0);
`endif
        fault_b = 1'b0;

        // Second load restarts at AB=0 and clears err
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_restart_err_clear", {err_b, err_addr_b}, 0);
        feed_b(~pat(0), ok);
        wait_write_b(ok);
        chk("b_restart_addr0", {ok, ab_b}, {1'b1, 10'd0});
        feed_fail = 0;
        for (int k = 1; k < 300; k++) begin
            feed_b(~pat(k), ok);
            if (!ok) feed_fail++;
        end
        feed_b(~pat(300), ok);
        if (!ok) feed_fail++;
        chk("b_reload_feeds", feed_fail, 0);
        wait_write_b(ok);
        chk("b_write_300", {ok, plseln_b, ab_b}, {1'b1, 1'b0, 10'd300});

        // Reset mid-access: idle bus before the next clock edge
        #2 RSTn = 1'b0;
        #1;
        chk("rst_async_plseln", plseln_b, 1);
        chk("rst_async_bus", {wdn_b, rw_b, ab_b, db_out_b, busy_b, s_ready_b},
            {1'b1, 1'b1, 10'd0, 8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        chk("partial_kept", {ram_b[299], ram_b[301]}, {~pat(299), pat(301)});

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        feed_b(8'hC3, ok);
        wait_write_b(ok);
        chk("after_rst_addr0", {ok, ab_b, db_out_b}, {1'b1, 10'd0, 8'hC3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
